// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state, symbol and segment definitions for the countdown display
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, GO} state_t;
  localparam logic [2:0] SYM_0     = 3'd0;
  localparam logic [2:0] SYM_1     = 3'd1;
  localparam logic [2:0] SYM_2     = 3'd2;
  localparam logic [2:0] SYM_3     = 3'd3;
  localparam logic [2:0] SYM_DASH  = 3'd4;
  localparam logic [2:0] SYM_G     = 3'd5;
  localparam logic [2:0] SYM_BLANK = 3'd6;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: symbol to active-low {g,f,e,d,c,b,a} pattern; unknown symbols go blank
module seg7_encode
  import countdown_pkg::*;
(
  input  logic [2:0] sym,
  output logic [6:0] seg
);
  assign seg = sym == SYM_0    ? SEG_0 :
               sym == SYM_1    ? SEG_1 :
               sym == SYM_2    ? SEG_2 :
               sym == SYM_3    ? SEG_3 :
               sym == SYM_DASH ? SEG_DASH :
               sym == SYM_G    ? SEG_G : SEG_BLANK;
endmodule

// File: rtl/countdown_display.sv
// countdown_display: drives the 4-digit display from the countdown sequencer and pulses on GO entry
module countdown_display
  import countdown_pkg::*;
#(
  parameter int HOLD_TICKS = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic [1:0] anode,
  input  logic       countdown_in_action,
  input  logic       countdown_done,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       go_pulse,
  output logic       display_busy
);
  localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);
  state_t          r_state, w_next;
  logic            r_done_q;
  logic [1:0]      r_dig;
  logic [HW-1:0]   r_hold, w_hold_nx;
  logic            w_edge;
  logic [2:0]      w_sym;
  logic [6:0]      w_seg;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_go, r_busy;
  assign w_edge = countdown_done & ~r_done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_done_q <= 1'b0;
      r_dig    <= 2'd0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_next;
      r_done_q <= countdown_done;
      r_dig    <= r_dig + {1'b0, scan_tick};
      r_hold   <= w_hold_nx;
    end
  end
  // A done edge outranks everything, including a scan_tick that would otherwise decrement the hold
  always_comb begin
    w_next    = r_state;
    w_hold_nx = r_hold;
    if (w_edge) begin
      w_next    = GO;
      w_hold_nx = HOLD_LOAD;
    end else if (countdown_in_action && r_state != COUNT) begin
      w_next = COUNT;
    end else if (r_state == COUNT && !countdown_in_action) begin
      w_next = IDLE;
    end else if (r_state == GO && scan_tick) begin
      if (r_hold == '0) w_next = IDLE;
      else w_hold_nx = r_hold - 1'b1;
    end
  end
  always_comb begin
    w_sym = r_state == COUNT ? (r_dig == 2'd0 ? {1'b0, 2'd3 - anode} :
                                r_dig <= anode ? SYM_DASH : SYM_BLANK) :
            r_state == GO    ? (r_dig == 2'd0 ? SYM_0 :
                                r_dig == 2'd1 ? SYM_G : SYM_BLANK) : SYM_BLANK;
  end
  seg7_encode u_enc (.sym(w_sym), .seg(w_seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an   <= 4'b1111;
      r_seg  <= SEG_BLANK;
      r_go   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_an   <= ~(4'b0001 << r_dig);
      r_seg  <= w_seg;
      r_go   <= w_edge;
      r_busy <= w_next != IDLE;
    end
  end
  assign an           = r_an;
  assign seg          = r_seg;
  assign dp           = 1'b1;
  assign go_pulse     = r_go;
  assign display_busy = r_busy;
endmodule
